dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: core load/store unit;
  - port 1: loader/debug DMA.
- Sits between the requesters and the data memory. Drives the memory's address, write-enable and write-data, and consumes its combinational read data.
- Arbitration is round-robin with burst ownership, bounded by a burst limit to prevent starvation.
- Read data is returned registered, one cycle after grant.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/rr_burst_arb.sv | 111 +++++++++++
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package : dmem_pkg
// Brief   : Shared types and constants for the data-memory arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Requester indices (1 bit: also used as the stored "last owner")
    localparam logic C_PORT0 = 1'b0;  // core load/store unit
    localparam logic C_PORT1 = 1'b1;  // loader / debug DMA

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : dmem_arbiter_if
// Brief     : Requester handshakes and memory-side bus of the data-memory
//             arbiter. slave = arbiter side, master = environment side.
// Rev       : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [DATA_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wd0;
    logic [DATA_WIDTH-1:0] wd1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic                  rerr0;
    logic                  rerr1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        output gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
               mem_addr, mem_we, mem_wd
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
        input  gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
               mem_addr, mem_we, mem_wd
    );

endinterface
`default_nettype wire

// File: rtl/rr_burst_arb.sv
`default_nettype none
// ============================================================================
// Module : rr_burst_arb
// Brief  : Two-port round-robin arbiter with burst ownership. The owner keeps
//          the grant while it requests, but yields after MAX_BURST consecutive
//          grants if the other port is waiting.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_burst_arb
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int                CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  C_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State, last-owner and burst counter registers; last=1 lets port 0 win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_last  <= C_PORT1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and grant decode; grants are forced low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        gnt         = 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (req[C_PORT0] && (!req[C_PORT1] || r_last == C_PORT1)) begin
                    gnt[C_PORT0] = 1'b1;
                    w_state_nxt  = ST_OWN0;
                    w_cnt_nxt    = C_ONE;
                end else if (req[C_PORT1]) begin
                    gnt[C_PORT1] = 1'b1;
                    w_state_nxt  = ST_OWN1;
                    w_cnt_nxt    = C_ONE;
                end
            end

            ST_OWN0: begin
                w_last_nxt = C_PORT0;
                if (req[C_PORT0] && (!req[C_PORT1] || r_cnt < C_MAX)) begin
                    gnt[C_PORT0] = 1'b1;
                    if (r_cnt < C_MAX) begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end else if (req[C_PORT1]) begin
                    gnt[C_PORT1] = 1'b1;
                    w_state_nxt  = ST_OWN1;
                    w_cnt_nxt    = C_ONE;
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                end
            end

            ST_OWN1: begin
                w_last_nxt = C_PORT1;
                if (req[C_PORT1] && (!req[C_PORT0] || r_cnt < C_MAX)) begin
                    gnt[C_PORT1] = 1'b1;
                    if (r_cnt < C_MAX) begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end else if (req[C_PORT0]) begin
                    gnt[C_PORT0] = 1'b1;
                    w_state_nxt  = ST_OWN0;
                    w_cnt_nxt    = C_ONE;
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A grant during reset would let a write slip through at release
        if (!rst) begin
            gnt = 2'b00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares a single-port data memory between the core LSU (port 0)
//          and the loader/debug DMA (port 1). Drives the memory address /
//          write bus from the granted port and returns a registered response
//          one cycle after each grant.
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 106,
    parameter int MAX_BURST  = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] C_DEPTH = DATA_WIDTH'(DEPTH);

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_in_range0;
    logic       w_in_range1;

    assign w_req       = {bus.req1, bus.req0};
    assign w_in_range0 = (bus.addr0 < C_DEPTH);
    assign w_in_range1 = (bus.addr1 < C_DEPTH);

    rr_burst_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign bus.gnt0 = w_gnt[C_PORT0];
    assign bus.gnt1 = w_gnt[C_PORT1];

    // Memory bus mux: port 0 address is presented when idle; out-of-range writes are dropped
    always_comb begin
        bus.mem_addr = bus.addr0;
        bus.mem_wd   = bus.wd0;
        bus.mem_we   = 1'b0;
        if (w_gnt[C_PORT1]) begin
            bus.mem_addr = bus.addr1;
            bus.mem_wd   = bus.wd1;
            bus.mem_we   = bus.we1 & w_in_range1;
        end else if (w_gnt[C_PORT0]) begin
            bus.mem_we   = bus.we0 & w_in_range0;
        end
    end

    // Port 0 response: one-cycle pulse; read data captured, write leaves rdata untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rvalid0 <= 1'b0;
            bus.rerr0   <= 1'b0;
            bus.rdata0  <= '0;
        end else begin
            bus.rvalid0 <= w_gnt[C_PORT0];
            bus.rerr0   <= w_gnt[C_PORT0] & ~w_in_range0;
            if (w_gnt[C_PORT0] && !bus.we0) begin
                bus.rdata0 <= w_in_range0 ? bus.mem_rd : '0;
            end
        end
    end

    // Port 1 response: independent of port 0 so a switch can overlap the old owner's reply
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rvalid1 <= 1'b0;
            bus.rerr1   <= 1'b0;
            bus.rdata1  <= '0;
        end else begin
            bus.rvalid1 <= w_gnt[C_PORT1];
            bus.rerr1   <= w_gnt[C_PORT1] & ~w_in_range1;
            if (w_gnt[C_PORT1] && !bus.we1) begin
                bus.rdata1 <= w_in_range1 ? bus.mem_rd : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed self-checking bench for dmem_arbiter with a response
//          scoreboard and a behavioural single-port memory.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 106;
    localparam int MAXB  = 4;

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    rsp_t        q0[$];
    rsp_t        q1[$];
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [31:0] ref_mem [DEPTH];

    dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Behavioural memory: loads its image on the first edge, then commits writes
    logic [31:0] dmem [DEPTH];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (bus.mem_we && bus.mem_addr < DEPTH) begin
            dmem[bus.mem_addr[6:0]] <= bus.mem_wd;
        end
    end
    assign bus.mem_rd = (bus.mem_addr < DEPTH) ? dmem[bus.mem_addr[6:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wd0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wd1 = d1;
    endtask

    // Expected response for an access granted this cycle; reference memory follows writes
    function automatic rsp_t make_rsp(input logic w, input logic [31:0] a, input logic [31:0] d);
        rsp_t e;
        logic in;
        in     = (a < DEPTH);
        e.err  = !in;
        e.wr   = w;
        e.data = (in && !w) ? ref_mem[a] : 32'h0;
        if (w && in) ref_mem[a] = d;
        return e;
    endfunction

    // One clock: check responses due now, then grants/memory drive, then record new accesses
    task automatic cycle(input string tag, input logic eg0, input logic eg1);
        rsp_t e;
        logic in0, in1;
        @(negedge clk);
        if (q0.size() != 0) begin
            e = q0.pop_front();
            if (!e.wr) exp_rd0 = e.data;
            chk({tag, "/rvalid0"}, 32'(bus.rvalid0), 32'd1);
            chk({tag, "/rerr0"},   32'(bus.rerr0),   32'(e.err));
            chk({tag, "/rdata0"},  bus.rdata0,       exp_rd0);
        end else begin
            chk({tag, "/rvalid0"}, 32'(bus.rvalid0), 32'd0);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            if (!e.wr) exp_rd1 = e.data;
            chk({tag, "/rvalid1"}, 32'(bus.rvalid1), 32'd1);
            chk({tag, "/rerr1"},   32'(bus.rerr1),   32'(e.err));
            chk({tag, "/rdata1"},  bus.rdata1,       exp_rd1);
        end else begin
            chk({tag, "/rvalid1"}, 32'(bus.rvalid1), 32'd0);
        end
        in0 = (bus.addr0 < DEPTH);
        in1 = (bus.addr1 < DEPTH);
        chk({tag, "/gnt0"},     32'(bus.gnt0),   32'(eg0));
        chk({tag, "/gnt1"},     32'(bus.gnt1),   32'(eg1));
        chk({tag, "/mem_we"},   32'(bus.mem_we), 32'((eg0 & bus.we0 & in0) | (eg1 & bus.we1 & in1)));
        chk({tag, "/mem_addr"}, bus.mem_addr,    eg1 ? bus.addr1 : bus.addr0);
        if (eg0) q0.push_back(make_rsp(bus.we0, bus.addr0, bus.wd0));
        if (eg1) q1.push_back(make_rsp(bus.we1, bus.addr1, bus.wd1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        exp_rd0 = '0;
        exp_rd1 = '0;

        // Reset with a pending request: nothing may be granted
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'd3, 32'h5555_5555, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst/gnt0",    32'(bus.gnt0),    32'd0);
        chk("rst/mem_we",  32'(bus.mem_we),  32'd0);
        chk("rst/rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("rst/rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("rst/rerr0",   32'(bus.rerr0),   32'd0);
        chk("rst/rerr1",   32'(bus.rerr1),   32'd0);
        chk("rst/rdata0",  bus.rdata0,       32'd0);
        chk("rst/rdata1",  bus.rdata1,       32'd0);

        // First tie after reset goes to port 0, then port 1 once port 0 drops
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'd7, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0);
        cycle("tie0", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd7, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0);
        cycle("tie1", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("idle_a", 1'b0, 1'b0);

        // Port 0 write then read-back of address 5
        drive(1'b1, 1'b1, 32'd5, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("wr5", 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("rd5", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("idle_b", 1'b0, 1'b0);

        // Port 1 single read leaves last=1 so port 0 leads the contention burst
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        cycle("rd2", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("idle_c", 1'b0, 1'b0);

        // Continuous contention: 0,0,0,0,1,1,1,1,0,0 with no gap cycles
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 32'(20 + k), 32'd0, 1'b1, 1'b0, 32'(60 + k), 32'd0);
            cycle($sformatf("burst%0d", k), ((k / MAXB) % 2) == 0, ((k / MAXB) % 2) == 1);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("idle_d", 1'b0, 1'b0);

        // Out-of-range write (blocked), old word at 105, out-of-range read
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd106, 32'hFFFF_FFFF);
        cycle("wr106", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd105, 32'd0);
        cycle("rd105", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd200, 32'd0);
        cycle("rd200", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("idle_e", 1'b0, 1'b0);

        // Reset in the middle of a port 1 burst, with a write granted but not yet committed
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd40, 32'd0);
        cycle("rd40", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd41, 32'd0);
        cycle("rd41", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd10, 32'h1234_5678);
        chk("pre_rst/rvalid1", 32'(bus.rvalid1), 32'd1);
        chk("pre_rst/rdata1",  bus.rdata1,       init_val(41));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst/gnt1",    32'(bus.gnt1),    32'd0);
        chk("mid_rst/mem_we",  32'(bus.mem_we),  32'd0);
        chk("mid_rst/rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("mid_rst/rerr1",   32'(bus.rerr1),   32'd0);
        chk("mid_rst/rdata1",  bus.rdata1,       32'd0);
        chk("mid_rst/rdata0",  bus.rdata0,       32'd0);
        q0.delete();
        q1.delete();
        exp_rd0 = '0;
        exp_rd1 = '0;
        @(posedge clk);
        #1;
        chk("in_rst/gnt1", 32'(bus.gnt1), 32'd0);

        // After release port 0 wins the tie; address 10 still holds its original word
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'd10, 32'd0, 1'b1, 1'b0, 32'd11, 32'd0);
        cycle("post_rst_tie", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd11, 32'd0);
        cycle("post_rst_sw", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("idle_f", 1'b0, 1'b0);
        cycle("idle_g", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
